// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone classic responder with a 16-bit prescaled up-counter.
// The 8-bit register map sits at BASE_ADDR+0..7. CNT_H is at +6, matching the
// EFB counter layout. A CNT_L read latches the high byte into a shadow
// register, so a following CNT_H read returns a coherent 16-bit value.
// Optional feature macro: WB_TIMER_ERR_EN.
// When this macro is defined, the module adds a wb_err_o port. Out-of-range
// accesses and writes to CNT_H/CNT_L then raise wb_err_o instead of wb_ack_o,
// and they have no side effects.
module wb_timer_slave #(
  parameter logic [7:0]  BASE_ADDR   = 8'h60,
  parameter logic [7:0]  PRESC_RESET = 8'h00,
  parameter logic [15:0] TOP_RESET   = 16'hFFFF
) (
  input  logic        i_Clock,
  input  logic        i_Resetn,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        o_Irq,
  output logic [15:0] o_Count
`ifdef WB_TIMER_ERR_EN
  ,
  output logic        wb_err_o
`endif
);

  // Bus response registers
  logic        r_ack;
  logic [7:0]  r_dat;

  // Control / status registers
  logic        r_en;
  logic        r_irq_en;
  logic [7:0]  r_presc;
  logic [15:0] r_top;
  logic        r_ovf;

  // Counting state
  logic [7:0]  r_presc_cnt;
  logic [15:0] r_cnt;
  logic [7:0]  r_shadow;
  logic        r_shadow_vld;

  logic        w_busy;
  logic        w_req;
  logic [8:0]  w_diff;
  logic        w_in_range;
  logic [2:0]  w_off;
  logic        w_bad;
  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic        w_rd_acc;
  logic        w_clr;
  logic        w_tick;
  logic        w_wrap;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic [7:0]  w_rdata;

`ifdef WB_TIMER_ERR_EN
  logic        r_err;
  assign w_busy   = r_ack | r_err;
  assign w_bad    = ~w_in_range | (wb_we_i & (w_off[2:1] == 2'b11));
  assign wb_err_o = r_err;
`else
  assign w_busy   = r_ack;
  assign w_bad    = 1'b0;
`endif

  // A new request is only accepted while no response is outstanding, so a
  // held strobe sees acks on alternate cycles.
  assign w_req      = wb_cyc_i & wb_stb_i & ~w_busy;
  assign w_diff     = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_diff[8:3] == 6'd0);
  assign w_off      = w_diff[2:0];

  assign w_acc    = w_req & w_in_range & ~w_bad;
  assign w_wr     = w_acc & wb_we_i;
  assign w_rd_acc = w_acc & ~wb_we_i;
  assign w_rd     = w_req & ~wb_we_i & ~w_bad;

  // A CLR write takes priority over any tick in the same cycle.
  assign w_clr     = w_wr & (w_off == 3'd0) & wb_dat_i[1];
  assign w_tick    = r_en & (r_presc_cnt == r_presc);
  assign w_wrap    = (r_cnt == r_top) | (r_cnt == 16'hFFFF);
  assign w_ovf_set = w_tick & ~w_clr & w_wrap;
  assign w_ovf_clr = w_wr & (w_off == 3'd5) & wb_dat_i[0];

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign o_Irq    = r_ovf & r_irq_en;
  assign o_Count  = r_cnt;

  // Read data multiplexer for the decoded register window
  always_comb begin
    w_rdata = 8'h00;
    if (w_in_range) begin
      case (w_off)
        3'd0:    w_rdata = {5'b0, r_irq_en, 1'b0, r_en};
        3'd1:    w_rdata = r_presc;
        3'd2:    w_rdata = r_top[7:0];
        3'd3:    w_rdata = r_top[15:8];
        3'd5:    w_rdata = {7'b0, r_ovf};
        3'd6:    w_rdata = r_shadow_vld ? r_shadow : r_cnt[15:8];
        3'd7:    w_rdata = r_cnt[7:0];
        default: w_rdata = 8'h00;
      endcase
    end
  end

  // Bus response: one-cycle ack (or err) with read data valid alongside it
  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_ack <= 1'b0;
      r_dat <= 8'h00;
`ifdef WB_TIMER_ERR_EN
      r_err <= 1'b0;
`endif
    end else begin
      r_ack <= w_req & ~w_bad;
      r_dat <= w_rd ? w_rdata : 8'h00;
`ifdef WB_TIMER_ERR_EN
      r_err <= w_req & w_bad;
`endif
    end
  end

  // Writable configuration registers (CLR is a strobe and is not stored)
  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_presc  <= PRESC_RESET;
      r_top    <= TOP_RESET;
    end else if (w_wr) begin
      case (w_off)
        3'd0: begin
          r_en     <= wb_dat_i[0];
          r_irq_en <= wb_dat_i[2];
        end
        3'd1:    r_presc      <= wb_dat_i;
        3'd2:    r_top[7:0]   <= wb_dat_i;
        3'd3:    r_top[15:8]  <= wb_dat_i;
        default: ;
      endcase
    end
  end

  // Prescaler and counter; the compare uses the registered TOP of this cycle
  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_presc_cnt <= 8'h00;
      r_cnt       <= 16'h0000;
    end else if (w_clr) begin
      r_presc_cnt <= 8'h00;
      r_cnt       <= 16'h0000;
    end else if (w_tick) begin
      r_presc_cnt <= 8'h00;
      r_cnt       <= w_wrap ? 16'h0000 : r_cnt + 16'd1;
    end else if (r_en) begin
      r_presc_cnt <= r_presc_cnt + 8'd1;
    end
  end

  // Overflow flag: a set in the same cycle as a clear wins
  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // High-byte shadow: set on a CNT_L read, consumed by the next CNT_H read
  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_shadow     <= 8'h00;
      r_shadow_vld <= 1'b0;
    end else if (w_rd_acc && (w_off == 3'd7)) begin
      r_shadow     <= r_cnt[15:8];
      r_shadow_vld <= 1'b1;
    end else if (w_rd_acc && (w_off == 3'd6)) begin
      r_shadow_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_timer_slave.sv
// Directed testbench for wb_timer_slave (default base address 0x60).
module tb_wb_timer_slave;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [7:0]  adr   = 8'h00;
  logic [7:0]  wdat  = 8'h00;
  logic [7:0]  dat_o;
  logic        ack;
  logic        irq;
  logic [15:0] cnt;
  logic        err;

`ifdef WB_TIMER_ERR_EN
  localparam logic ERRB = 1'b1;
`else
  localparam logic ERRB = 1'b0;
  assign err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  wb_timer_slave dut (
    .i_Clock (clk),
    .i_Resetn(rstn),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_we_i (we),
    .wb_adr_i(adr),
    .wb_dat_i(wdat),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack),
    .o_Irq   (irq),
    .o_Count (cnt)
`ifdef WB_TIMER_ERR_EN
    ,
    .wb_err_o(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One single-beat transfer: strobe on a falling edge, expect the response
  // after exactly one rising edge.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic exp_err, output logic [7:0] r);
    @(negedge clk);
    chk("idle_ack", {31'b0, ack}, 32'd0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk);
    @(negedge clk);
    chk("ack", {31'b0, ack}, {31'b0, ~exp_err});
    chk("err", {31'b0, err}, {31'b0, exp_err});
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    xfer(1'b1, a, d, 1'b0, r);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] r;
    xfer(1'b0, a, 8'h00, 1'b0, r);
    chk(tag, {24'b0, r}, {24'b0, exp});
  endtask

  task automatic wait_val(input logic [15:0] v, input int budget, output int n);
    n = 0;
    while (cnt !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] c;
    logic [7:0] r;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", {24'b0, dat_o}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_cnt", {16'b0, cnt}, 32'd0);
    rstn = 1'b1;

    rd("ctrl_rst", 8'h60, 8'h00);
    rd("presc_rst", 8'h61, 8'h00);
    rd("topl_rst", 8'h62, 8'hFF);
    rd("toph_rst", 8'h63, 8'hFF);
    @(negedge clk);
    chk("dat_idle", {24'b0, dat_o}, 32'd0);

    // prescaled counting and overflow
    wr(8'h61, 8'h03);
    wr(8'h62, 8'h05);
    wr(8'h63, 8'h00);
    wr(8'h60, 8'h05);
    wait_val(16'd1, 100, n);
    wait_val(16'd2, 100, n);
    chk("period", n, 4);
    wait_val(16'd5, 100, n);
    chk("irq_before", {31'b0, irq}, 32'd0);
    wait_val(16'd0, 100, n);
    chk("wrap_period", n, 4);
    chk("irq_wrap", {31'b0, irq}, 32'd1);
    rd("status_set", 8'h65, 8'h01);
    wr(8'h65, 8'h01);
    rd("status_clr", 8'h65, 8'h00);
    chk("irq_clr", {31'b0, irq}, 32'd0);

    // reserved and out-of-range accesses
    wr(8'h64, 8'hAA);
    rd("reserved", 8'h64, 8'h00);
    xfer(1'b0, 8'h10, 8'h00, ERRB, r);
    chk("out_range", {24'b0, r}, 32'd0);

    // freeze with EN=0
    wr(8'h60, 8'h00);
    c = cnt;
    repeat (10) @(negedge clk);
    chk("frozen", {16'b0, cnt}, {16'b0, c});

    // coherent 16-bit read across a carry into the high byte
    wr(8'h60, 8'h02);
    chk("clr", {16'b0, cnt}, 32'd0);
    wr(8'h61, 8'h00);
    wr(8'h62, 8'hFF);
    wr(8'h63, 8'hFF);
    wr(8'h65, 8'h01);
    wr(8'h60, 8'h01);
    wait_val(16'h12FE, 10000, n);
    chk("reach_12fe", {16'b0, cnt}, 32'h12FE);
    rd("cnt_l", 8'h67, 8'hFF);
    rd("cnt_h_shadow", 8'h66, 8'h12);
    rd("cnt_h_live", 8'h66, 8'h13);
    wr(8'h60, 8'h00);

    // CLR colliding with a wrap tick, then OVF set colliding with clear
    wr(8'h60, 8'h02);
    wr(8'h62, 8'h10);
    wr(8'h63, 8'h00);
    wr(8'h65, 8'h01);
    wr(8'h60, 8'h01);
    wait_val(16'h000F, 100, n);
    chk("reach_0f", {16'b0, cnt}, 32'h000F);
    wr(8'h60, 8'h03);
    chk("clr_wins", {16'b0, cnt}, 32'd0);
    rd("ovf_after_clr", 8'h65, 8'h00);
    wait_val(16'h000F, 100, n);
    chk("reach_0f_2", {16'b0, cnt}, 32'h000F);
    wr(8'h65, 8'h01);
    rd("set_wins", 8'h65, 8'h01);
    wr(8'h65, 8'h01);
    rd("ovf_cleared", 8'h65, 8'h00);
    wr(8'h60, 8'h00);

    // held strobe gives alternating acks; async reset drops ack at once
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h66;
    chk("hold_ack0", {31'b0, ack}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_ack%0d", i), {31'b0, ack}, i % 2);
    end
    rstn = 1'b0;
    #1;
    chk("rst_async_ack", {31'b0, ack}, 32'd0);
    chk("rst_async_cnt", {16'b0, cnt}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

`ifdef WB_TIMER_ERR_EN
    // error responses have no side effects
    wr(8'h60, 8'h01);
    wr(8'h60, 8'h00);
    c = cnt;
    xfer(1'b1, 8'h67, 8'h55, 1'b1, r);
    chk("err_no_write", {16'b0, cnt}, {16'b0, c});
    xfer(1'b1, 8'h08, 8'h02, 1'b1, r);
    chk("err_no_clr", {16'b0, cnt}, {16'b0, c});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
